dbg_step_ctrl: RTL and testbench

DBG_STEP_CTRL -- requirements
Module: dbg_step_ctrl

---
 rtl/dbg_pkg.sv | 36 +++
 rtl/dbg_sync_edge.sv | 49 ++++
 rtl/dbg_step_ctrl.sv | 156 +++++++++++++++
 tb/tb_dbg_step_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug step controller.
// Contents: FSM state encoding, halt_why codes, mode codes and a helper that
// resolves the reason for a halt from the active halt conditions.
package dbg_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StStep  = 2'd1,
    StBurst = 2'd2,
    StFree  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    WhyReset = 3'd0,
    WhyDone  = 3'd1,
    WhyBp    = 3'd2,
    WhyTrap  = 3'd3,
    WhyUser  = 3'd4
  } halt_why_e;

  localparam logic [1:0] ModeStep  = 2'b00;
  localparam logic [1:0] ModeBurst = 2'b01;
  localparam logic [1:0] ModeFree  = 2'b10;
  localparam logic [1:0] ModeRsvd  = 2'b11;

  // Priority: trap, then breakpoint, otherwise the user halt must be the cause.
  function automatic halt_why_e halt_cause(input logic trap, input logic bp_hit);
    if (trap) begin
      return WhyTrap;
    end else if (bp_hit) begin
      return WhyBp;
    end
    return WhyUser;
  endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Synchronizer plus rising-edge detector for a VIO-driven level.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, clears every flop
//   d_i     - asynchronous level input
//   pulse_o - one-cycle pulse on a synchronized 0->1 transition
module dbg_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q;
  // valid_q[i] marks that stage i (and at index Stages, prev_q) holds a sample
  // taken after reset; a level already high at reset never looks like an edge.
  logic [Stages:0]   valid_q, valid_d;

  always_comb begin
    sync_d     = '0;
    valid_d    = '0;
    sync_d[0]  = d_i;
    valid_d[0] = 1'b1;
    for (int i = 1; i < int'(Stages); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    for (int i = 1; i <= int'(Stages); i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= sync_q[Stages-1];
      valid_q <= valid_d;
    end
  end

  assign pulse_o = sync_q[Stages-1] & ~prev_q & valid_q[Stages];

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug step controller: gates the CPU clock enable for single step,
// run-N bursts and free run, with breakpoint, trap and user halt.
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   go_req_i, halt_req_i - VIO levels, acted on at their rising edges
//   mode_i              - 00 step, 01 run N, 10 free run, 11 as step
//   run_n_i             - burst length for run N
//   bp_en_i, bp_addr_i  - breakpoint enable and PC
//   pc_i, scause_i      - CPU PC and exception cause (nonzero = trap)
//   cpu_ce_o            - CPU clock enable, one CPU cycle per high clk cycle
//   halted_o, halt_why_o - halt status and reason
//   ce_count_o          - cpu_ce pulses since reset (wraps)
//   remaining_o         - cycles left in the current burst
module dbg_step_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_req_i,
  input  logic             halt_req_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] run_n_i,
  input  logic             bp_en_i,
  input  logic [31:0]      bp_addr_i,
  input  logic [31:0]      pc_i,
  input  logic [4:0]       scause_i,
  output logic             cpu_ce_o,
  output logic             halted_o,
  output logic [2:0]       halt_why_o,
  output logic [31:0]      ce_count_o,
  output logic [CNT_W-1:0] remaining_o
);

  state_e           state_q, state_d;
  halt_why_e        why_q, why_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             go_pulse, halt_pulse;
  logic             trap, bp_hit, stop, ce;

  dbg_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_go_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (go_req_i),
    .pulse_o (go_pulse)
  );

  dbg_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_halt_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (halt_req_i),
    .pulse_o (halt_pulse)
  );

  always_comb begin
    state_d = state_q;
    why_d   = why_q;
    rem_d   = rem_q;
    first_d = first_q;
    ce      = 1'b0;

    trap   = (scause_i != 5'd0);
    // first_q masks the breakpoint so a run can start from the breakpoint PC.
    bp_hit = bp_en_i && (pc_i == bp_addr_i) && !first_q;
    stop   = trap || bp_hit || halt_pulse;

    unique case (state_q)
      StHalt: begin
        if (halt_pulse) begin
          // A lone halt edge while halted leaves the reason untouched.
          if (go_pulse) begin
            why_d = WhyUser;
          end
        end else if (go_pulse) begin
          first_d = 1'b1;
          case (mode_i)
            ModeBurst: begin
              if (run_n_i == '0) begin
                why_d = WhyDone;
              end else begin
                state_d = StBurst;
                rem_d   = run_n_i;
              end
            end
            ModeFree: state_d = StFree;
            default:  state_d = StStep;
          endcase
        end
      end

      StStep: begin
        ce      = 1'b1;
        state_d = StHalt;
        why_d   = WhyDone;
      end

      StBurst: begin
        first_d = 1'b0;
        if (stop) begin
          state_d = StHalt;
          why_d   = halt_cause(trap, bp_hit);
        end else begin
          ce    = 1'b1;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StHalt;
            why_d   = WhyDone;
          end
        end
      end

      StFree: begin
        first_d = 1'b0;
        if (stop) begin
          state_d = StHalt;
          why_d   = halt_cause(trap, bp_hit);
        end else begin
          ce = 1'b1;
        end
      end
    endcase

    cnt_d = cnt_q + {31'd0, ce};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StHalt;
      why_q   <= WhyReset;
      cnt_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      why_q   <= why_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  assign cpu_ce_o    = ce;
  assign halted_o    = (state_q == StHalt);
  assign halt_why_o  = why_q;
  assign ce_count_o  = cnt_q;
  assign remaining_o = rem_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Self-checking bench for dbg_step_ctrl: a table of run scenarios, hand-written
// corner sequences, and a randomized run against a reference model.
module tb_dbg_step_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] run_n = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic [4:0]  scause = '0;
  logic        cpu_ce;
  logic        halted;
  logic [2:0]  halt_why;
  logic [31:0] ce_count;
  logic [15:0] remaining;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic [15:0] rem_log[$];

  always #5 clk = ~clk;

  dbg_step_ctrl #(
    .SYNC_STAGES (S),
    .CNT_W       (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .go_req_i    (go),
    .halt_req_i  (halt),
    .mode_i      (mode),
    .run_n_i     (run_n),
    .bp_en_i     (bp_en),
    .bp_addr_i   (bp_addr),
    .pc_i        (pc),
    .scause_i    (scause),
    .cpu_ce_o    (cpu_ce),
    .halted_o    (halted),
    .halt_why_o  (halt_why),
    .ce_count_o  (ce_count),
    .remaining_o (remaining)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: sample at negedge, emulate the CPU advancing its PC.
  task automatic cyc();
    logic ce_s;
    @(negedge clk);
    ce_s = cpu_ce;
    if (ce_s === 1'b1) begin
      pulses++;
      rem_log.push_back(remaining);
    end
    @(posedge clk);
    #1;
    if (ce_s === 1'b1) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go = 1'b0;
    halt = 1'b0;
    scause = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (S + 3) begin
      @(posedge clk);
      #1;
    end
    pc = '0;
    pulses = 0;
    rem_log.delete();
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] run_n;
    logic        bp_en;
    logic [31:0] bp_addr;
    int          sc_mode;  // 0 none, 1 trap when pulses==sc_n, 2 always trap
    int          sc_n;
    int          exp_pulses;
    logic [2:0]  exp_why;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    mode = v.mode;
    run_n = v.run_n;
    bp_en = v.bp_en;
    bp_addr = v.bp_addr;
    go = 1'b1;
    repeat (40) begin
      scause = (v.sc_mode == 2 || (v.sc_mode == 1 && pulses == v.sc_n)) ? 5'h02 : 5'h00;
      cyc();
    end
    go = 1'b0;
    scause = '0;
  endtask

  // Reference model, expressed as a pulse budget rather than FSM states.
  bit   gq[$];
  bit   hq[$];
  bit   m_running, m_haltable, m_first, m_burst, m_free;
  int   m_budget;
  logic [2:0]  m_why;
  logic [31:0] m_count;
  logic [15:0] m_rem;

  function automatic bit edge_of(input bit q[$]);
    int n = q.size();
    if (n < S + 1) return 1'b0;
    return q[n-S] && !q[n-S-1];
  endfunction

  task automatic model_reset();
    m_running = 0;
    m_haltable = 0;
    m_first = 0;
    m_burst = 0;
    m_free = 0;
    m_budget = 0;
    m_why = 3'd0;
    m_count = '0;
    m_rem = '0;
    gq.delete();
    hq.delete();
  endtask

  bit gp, hp, trapc, bph, stopc, ce_e;

  initial begin
    vecs[0] = '{2'b00, 16'd0,  1'b0, 32'h0,  0, 0, 1, 3'd1};
    vecs[1] = '{2'b11, 16'd0,  1'b0, 32'h0,  0, 0, 1, 3'd1};
    vecs[2] = '{2'b01, 16'd5,  1'b0, 32'h0,  0, 0, 5, 3'd1};
    vecs[3] = '{2'b01, 16'd0,  1'b0, 32'h0,  0, 0, 0, 3'd1};
    vecs[4] = '{2'b10, 16'd0,  1'b1, 32'h10, 0, 0, 4, 3'd2};
    vecs[5] = '{2'b10, 16'd0,  1'b1, 32'h8,  1, 2, 2, 3'd3};
    vecs[6] = '{2'b01, 16'd10, 1'b1, 32'hC,  0, 0, 3, 3'd2};
    vecs[7] = '{2'b01, 16'd3,  1'b1, 32'h0,  0, 0, 3, 3'd1};
    vecs[8] = '{2'b00, 16'd0,  1'b0, 32'h0,  2, 0, 1, 3'd1};
    vecs[9] = '{2'b10, 16'd0,  1'b0, 32'h0,  1, 6, 6, 3'd3};

    do_reset();
    @(negedge clk);
    chk("reset cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd1);
    chk("reset halt_why", {29'd0, halt_why}, 32'd0);
    chk("reset ce_count", ce_count, 32'd0);
    chk("reset remaining", {16'd0, remaining}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_vec(vecs[i]);
      chk($sformatf("vec%0d pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("vec%0d halt_why", i), {29'd0, halt_why}, {29'd0, vecs[i].exp_why});
      chk($sformatf("vec%0d halted", i), {31'd0, halted}, 32'd1);
      chk($sformatf("vec%0d ce_count", i), ce_count, vecs[i].exp_pulses);
      if (i == 2) begin
        chk("burst log size", rem_log.size(), 5);
        for (int k = 0; k < rem_log.size() && k < 5; k++)
          chk($sformatf("burst remaining %0d", k), {16'd0, rem_log[k]}, 5 - k);
        chk("burst remaining end", {16'd0, remaining}, 32'd0);
      end
      if (i == 4) begin
        // Step off the breakpoint PC.
        chk("bp pc", pc, 32'h10);
        repeat (4) cyc();
        pulses = 0;
        mode = 2'b00;
        go = 1'b1;
        repeat (10) cyc();
        go = 1'b0;
        chk("bp step pulses", pulses, 1);
        chk("bp step pc", pc, 32'h14);
        chk("bp step halt_why", {29'd0, halt_why}, 32'd1);
      end
    end

    // Reset in the middle of a long burst.
    do_reset();
    mode = 2'b01;
    run_n = 16'd100;
    go = 1'b1;
    repeat (10) cyc();
    chk("midburst running", {31'd0, halted}, 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    go = 1'b0;
    pulses = 0;
    repeat (10) cyc();
    chk("rst pulses", pulses, 0);
    chk("rst ce_count", ce_count, 32'd0);
    chk("rst remaining", {16'd0, remaining}, 32'd0);
    chk("rst halt_why", {29'd0, halt_why}, 32'd0);

    // Lone halt edge while halted, then go and halt together.
    do_reset();
    mode = 2'b00;
    go = 1'b1;
    repeat (10) cyc();
    go = 1'b0;
    repeat (5) cyc();
    halt = 1'b1;
    repeat (10) cyc();
    chk("halt in HALT why", {29'd0, halt_why}, 32'd1);
    chk("halt in HALT pulses", pulses, 1);
    halt = 1'b0;
    repeat (5) cyc();
    pulses = 0;
    go = 1'b1;
    halt = 1'b1;
    repeat (10) cyc();
    chk("go+halt pulses", pulses, 0);
    chk("go+halt why", {29'd0, halt_why}, 32'd4);
    chk("go+halt halted", {31'd0, halted}, 32'd1);

    // go level already high across reset is not an edge.
    rst = 1'b1;
    go = 1'b1;
    halt = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    pulses = 0;
    repeat (10) cyc();
    chk("go high at reset pulses", pulses, 0);
    go = 1'b0;
    repeat (5) cyc();
    go = 1'b1;
    repeat (10) cyc();
    go = 1'b0;
    chk("go after reset pulses", pulses, 1);

    // Randomized run against the reference model.
    rst = 1'b1;
    go = 1'b0;
    halt = 1'b0;
    scause = '0;
    pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) go = ~go;
      if ($urandom_range(0, 14) == 0) halt = ~halt;
      mode = 2'($urandom_range(0, 3));
      run_n = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 29) == 0) bp_addr = 32'($urandom_range(0, 15)) * 32'd4;
      scause = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      @(negedge clk);
      gp = edge_of(gq);
      hp = edge_of(hq);
      trapc = (scause != 5'd0);
      bph = bp_en && (pc == bp_addr) && !m_first;
      stopc = m_haltable && (trapc || bph || hp);
      ce_e = m_running && !stopc;
      chk($sformatf("rnd%0d cpu_ce", c), {31'd0, cpu_ce}, {31'd0, ce_e});
      chk($sformatf("rnd%0d halted", c), {31'd0, halted}, {31'd0, !m_running});
      chk($sformatf("rnd%0d halt_why", c), {29'd0, halt_why}, {29'd0, m_why});
      chk($sformatf("rnd%0d ce_count", c), ce_count, m_count);
      chk($sformatf("rnd%0d remaining", c), {16'd0, remaining}, {16'd0, m_rem});
      if (rst) begin
        model_reset();
      end else begin
        if (m_running) begin
          if (stopc) begin
            m_running = 0;
            m_why = trapc ? 3'd3 : (bph ? 3'd2 : 3'd4);
          end else begin
            m_count = m_count + 32'd1;
            if (m_burst) m_rem = m_rem - 16'd1;
            if (!m_free) begin
              m_budget--;
              if (m_budget == 0) begin
                m_running = 0;
                m_why = 3'd1;
              end
            end
          end
          m_first = 0;
        end else if (hp) begin
          if (gp) m_why = 3'd4;
        end else if (gp) begin
          m_first = 1;
          if (mode == 2'b01) begin
            if (run_n == 16'd0) begin
              m_first = 0;
              m_why = 3'd1;
            end else begin
              m_running = 1;
              m_haltable = 1;
              m_burst = 1;
              m_free = 0;
              m_budget = int'(run_n);
              m_rem = run_n;
            end
          end else if (mode == 2'b10) begin
            m_running = 1;
            m_haltable = 1;
            m_burst = 0;
            m_free = 1;
          end else begin
            m_running = 1;
            m_haltable = 0;
            m_burst = 0;
            m_free = 0;
            m_budget = 1;
          end
        end
        gq.push_back(go);
        hq.push_back(halt);
        if (gq.size() > S + 1) void'(gq.pop_front());
        if (hq.size() > S + 1) void'(hq.pop_front());
      end
      @(posedge clk);
      #1;
      if (ce_e) pc = (pc + 32'd4) & 32'h3C;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
